scan_sequencer: RTL
===================

# scan_sequencer

Parametrised frame scan generator for the GPU front end. It emits one (layer, x, y) coordinate beat per cycle to the downstream pixel pipeline over a valid/ready handshake. Layer iterates fastest, then x, then y. Compared with the previous counter it adds backpressure, a runtime active-layer count, early pixel termination, single-shot or continuous framing, abort, and position flags.

## Interface
- HOR_PIX, 480: screen width in pixels, ≥2
- VER_PIX, 272: screen height in pixels, ≥2
- NUM_LAYERS, 32: maximum layers per pixel, ≥2
- X_DEPTH, $clog2(HOR_PIX): x width
- Y_DEPTH, $clog2(VER_PIX): y width
- LAYER_DEPTH, $clog2(NUM_LAYERS): layer width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  begin a frame; honoured only in IDLE
- continuous  in  1  sampled on the frame-ending beat; 1 means start the next frame immediately
- abort  in  1  synchronous abort to IDLE
- num_layers_cfg  in  LAYER_DEPTH+1  active layers per pixel; latched on frame start
- skip_pixel  in  1  qualified by acceptance; marks the current beat as the last layer of its pixel
- out_ready  in  1  downstream accepts the beat
- out_valid  out  1  beat valid
- layer  out  LAYER_DEPTH  current layer index
- x  out  X_DEPTH  current column
- y  out  Y_DEPTH  current row
- sof  out  1  layer==0 && x==0 && y==0
- eol  out  1  x==HOR_PIX-1
- eof  out  1  eol && y==VER_PIX-1
- last_layer  out  1  layer==active_layers-1
- busy  out  1  state is RUN
- frame_done  out  1  one-cycle pulse after the frame-ending beat is accepted

## Operation
- States: IDLE and RUN. `out_valid` equals `busy` equals (state==RUN).
- IDLE → RUN: on `start`=1 and `abort`=0.
  - Counters are set to 0.
  - `active_layers` is latched from `num_layers_cfg`. A value of 0, or any value above NUM_LAYERS, is clamped to NUM_LAYERS.
- Beat accepted: `out_valid && out_ready`. Nothing advances unless a beat is accepted. Outputs hold while `out_valid && !out_ready`.
- Pixel end: accepted beat with `last_layer || skip_pixel`.
- Advance on an accepted beat:
  - Not a pixel end: layer+1.
  - Pixel end, not eol: layer=0, x+1.
  - Pixel end, eol, not eof: layer=0, x=0, y+1.
  - Pixel end with eof (the frame end):
    - `continuous`=1: stay in RUN, counters go to 0, and `active_layers` is re-latched from `num_layers_cfg`.
    - `continuous`=0: go to IDLE, counters go to 0.
- `skip_pixel` has no effect on a beat that is not accepted.
- `abort`:
  - Highest priority after reset, in any state.
  - Next cycle: IDLE, counters 0, `frame_done` stays 0.
  - `abort` and `start` together in IDLE leave the block in IDLE.
- `start` is ignored in RUN.
- Counter arithmetic:
  - Compares use one-bit-wider values, so x, y and layer never wrap past their maximum.
  - x ≤ HOR_PIX-1, y ≤ VER_PIX-1, layer ≤ active_layers-1 at all times.
- Flags are decoded from registered state only. They have no combinational path from any input. They are meaningful only while `out_valid`=1.

## Timing
- Reset values: state IDLE; `out_valid`, `busy` and `frame_done` 0; layer, x and y 0; `active_layers` NUM_LAYERS.
  - Flags follow the counters, so `sof`=1 and all other flags are 0.
- Start latency: `start` sampled in cycle N → `out_valid`=1 with (0,0,0) in cycle N+1.
- Throughput: one beat per cycle while `out_ready`=1. The frame-to-frame gap in continuous mode is zero cycles.
- `frame_done`:
  - Asserted in the cycle after the frame-ending beat is accepted.
  - Pulses in both single-shot and continuous mode.
  - Never asserted on abort.
- Reset asserted mid-frame clears all state immediately, asynchronously. There is no `frame_done`.
- All outputs are registered or decoded from registers. Inputs are sampled on the rising edge of `clk`.

## Test plan
Use HOR_PIX=4, VER_PIX=3, NUM_LAYERS=4.
- **Single frame.** Set `num_layers_cfg`=4, `continuous`=0, `out_ready`=1. Pulse `start`.
  - Expect 48 beats in layer/x/y order.
  - The beat at (3,3,2) has `eof`=1 and `last_layer`=1.
  - `frame_done` pulses on beat-cycle 49; `out_valid`=0 afterwards.
- **Clamp and runtime count.**
  - `num_layers_cfg`=2 → 24 beats, layers 0–1 only.
  - `num_layers_cfg`=0 → 48 beats.
  - `num_layers_cfg`=7 → 48 beats.
- **Backpressure.** Randomise `out_ready` at 50%.
  - Coordinates must be stable while stalled.
  - The beat sequence must be identical to the single-frame case.
  - Total accepted beats: 48.
- **skip_pixel.**
  - Assert with acceptance at (1,2,0) → next beat is (0,3,0).
  - Assert while `out_ready`=0 → no effect.
  - Assert at (0,3,2) → frame ends.
- **Continuous and abort.**
  - Run with `continuous`=1: (0,0,0) follows (3,3,2) in the next cycle; `frame_done`=1 in that same cycle.
  - Raise `abort` mid-frame: the next cycle is IDLE with counters 0 and no `frame_done`.
- **Async reset mid-frame.** Drop `rst` between clock edges at (2,1,1).
  - All outputs go to their reset values before the next edge.
  - The block restarts only on `start`.

Source files
------------

// File: rtl/scan_sequencer_if.sv
// Beat and control bundle between the frame scan generator and the pixel pipeline.
interface scan_sequencer_if #(
    parameter int LAYER_DEPTH = 5,
    parameter int X_DEPTH     = 9,
    parameter int Y_DEPTH     = 9
);
    logic                   start;
    logic                   continuous;
    logic                   abort;
    logic [LAYER_DEPTH:0]   num_layers_cfg;
    logic                   skip_pixel;
    logic                   out_ready;
    logic                   out_valid;
    logic [LAYER_DEPTH-1:0] layer;
    logic [X_DEPTH-1:0]     x;
    logic [Y_DEPTH-1:0]     y;
    logic                   sof;
    logic                   eol;
    logic                   eof;
    logic                   last_layer;
    logic                   busy;
    logic                   frame_done;

    modport master (
        input  start, continuous, abort, num_layers_cfg, skip_pixel, out_ready,
        output out_valid, layer, x, y, sof, eol, eof, last_layer, busy, frame_done
    );

    modport slave (
        output start, continuous, abort, num_layers_cfg, skip_pixel, out_ready,
        input  out_valid, layer, x, y, sof, eol, eof, last_layer, busy, frame_done
    );
endinterface

// File: rtl/scan_sequencer.sv
// Frame scan generator: one (layer,x,y) beat per cycle, first beat one cycle after start.
// Counters and flags hold while out_ready is low; frame_done pulses the cycle after the last beat.
module scan_sequencer #(
    parameter int HOR_PIX     = 480,
    parameter int VER_PIX     = 272,
    parameter int NUM_LAYERS  = 32,
    parameter int X_DEPTH     = $clog2(HOR_PIX),
    parameter int Y_DEPTH     = $clog2(VER_PIX),
    parameter int LAYER_DEPTH = $clog2(NUM_LAYERS)
) (
    input  logic             clk,
    input  logic             rst,
    scan_sequencer_if.master seq_if
);
    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    // Bounds held one bit wider so the compares cannot alias on power-of-two sizes.
    localparam logic [X_DEPTH:0]     X_LAST     = (X_DEPTH+1)'(HOR_PIX - 1);
    localparam logic [Y_DEPTH:0]     Y_LAST     = (Y_DEPTH+1)'(VER_PIX - 1);
    localparam logic [LAYER_DEPTH:0] LAYERS_MAX = (LAYER_DEPTH+1)'(NUM_LAYERS);

    state_t                 state_q, state_d;
    logic [LAYER_DEPTH-1:0] layer_q, layer_d;
    logic [X_DEPTH-1:0]     x_q, x_d;
    logic [Y_DEPTH-1:0]     y_q, y_d;
    logic [LAYER_DEPTH:0]   active_q, active_d;
    logic                   done_q, done_d;

    logic                   eol, eof, last_layer, accept, pixel_end;
    logic [LAYER_DEPTH:0]   cfg_clamped;

    assign eol        = ({1'b0, x_q} == X_LAST);
    assign eof        = eol && ({1'b0, y_q} == Y_LAST);
    assign last_layer = (({1'b0, layer_q} + (LAYER_DEPTH+1)'(1)) == active_q);
    assign accept     = (state_q == S_RUN) && seq_if.out_ready;
    assign pixel_end  = last_layer || seq_if.skip_pixel;

    assign cfg_clamped = ((seq_if.num_layers_cfg == '0) || (seq_if.num_layers_cfg > LAYERS_MAX))
                         ? LAYERS_MAX : seq_if.num_layers_cfg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            layer_q  <= '0;
            x_q      <= '0;
            y_q      <= '0;
            active_q <= LAYERS_MAX;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            layer_q  <= layer_d;
            x_q      <= x_d;
            y_q      <= y_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        layer_d  = layer_q;
        x_d      = x_q;
        y_d      = y_q;
        active_d = active_q;
        done_d   = 1'b0;

        if (seq_if.abort) begin
            state_d = S_IDLE;
            layer_d = '0;
            x_d     = '0;
            y_d     = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (seq_if.start) begin
                        state_d  = S_RUN;
                        layer_d  = '0;
                        x_d      = '0;
                        y_d      = '0;
                        active_d = cfg_clamped;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        if (!pixel_end) begin
                            layer_d = layer_q + LAYER_DEPTH'(1);
                        end else if (!eol) begin
                            layer_d = '0;
                            x_d     = x_q + X_DEPTH'(1);
                        end else if (!eof) begin
                            layer_d = '0;
                            x_d     = '0;
                            y_d     = y_q + Y_DEPTH'(1);
                        end else begin
                            layer_d = '0;
                            x_d     = '0;
                            y_d     = '0;
                            done_d  = 1'b1;
                            if (seq_if.continuous) begin
                                active_d = cfg_clamped;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign seq_if.out_valid  = (state_q == S_RUN);
    assign seq_if.busy       = (state_q == S_RUN);
    assign seq_if.layer      = layer_q;
    assign seq_if.x          = x_q;
    assign seq_if.y          = y_q;
    assign seq_if.sof        = (layer_q == '0) && (x_q == '0) && (y_q == '0);
    assign seq_if.eol        = eol;
    assign seq_if.eof        = eof;
    assign seq_if.last_layer = last_layer;
    assign seq_if.frame_done = done_q;
endmodule
